// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: digit/segment
// widths, the segment word type and the hex glyph table.
package ssd_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    // Active-high segment word, bit order {g,f,e,d,c,b,a}
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Hex nibble to segment pattern
    function automatic seg_t hex_to_seg(input logic [DIGIT_W-1:0] hex);
        return GLYPH[hex];
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Scan timebase: prescaler holding each digit for SCAN_DIV cycles, digit
// index stepping 0..NUM_DIGITS-1, and a frame tick during the wrap cycle.
// Ports:
//   clk, nrst     clock, async active-low reset
//   idx_o         current digit index
//   frame_tick_o  high for the one cycle in which the index wraps to 0
module ssd_scan_timer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             nrst,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_tick_o
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick_q, tick_d;
    logic             cnt_last, idx_last;

    // Next-state; tick is a lookahead so the registered pulse lands on the wrap cycle
    always_comb begin
        cnt_last = (cnt_q == CNT_W'(SCAN_DIV - 1));
        idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (cnt_last) begin
            cnt_d = '0;
            idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_W'(SCAN_DIV - 1)) && (idx_d == IDX_W'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            tick_q <= tick_d;
        end
    end

    assign idx_o        = idx_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment display controller with double-buffered
// value/enable/leading-zero-blank settings committed only at frame wrap.
// Optional blink support under macro SSD_SCAN_BLINK_EN (adds blink_mask input
// and BLINK_FRAMES parameter).
// Ports:
//   clk, nrst    clock, async active-low reset
//   load         capture value/digit_en/lzb_en (and blink_mask) into pending buffer
//   value        packed hex digits, [3:0] = digit 0
//   digit_en     per-digit enable
//   lzb_en       leading-zero blanking enable
//   seg_out      registered segments {g,f,e,d,c,b,a}
//   dig_sel      registered one-hot digit select
//   frame_tick   pulse on the wrap cycle
//   pending      pending buffer holds uncommitted data
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000
`ifdef SSD_SCAN_BLINK_EN
   ,parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lzb_en,
`ifdef SSD_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
    output logic [SEG_W-1:0]              seg_out,
    output logic [NUM_DIGITS-1:0]         dig_sel,
    output logic                          frame_tick,
    output logic                          pending
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = DIGIT_W * NUM_DIGITS;

    logic [IDX_W-1:0] idx;
    logic             tick;

    ssd_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk          (clk),
        .nrst         (nrst),
        .idx_o        (idx),
        .frame_tick_o (tick)
    );

    logic [VAL_W-1:0]      pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] pend_en_q,  pend_en_d,  act_en_q,  act_en_d;
    logic                  pend_lzb_q, pend_lzb_d, act_lzb_q, act_lzb_d;
    logic                  pending_q,  pending_d;
    seg_t                  seg_q,      seg_d;
    logic [NUM_DIGITS-1:0] dig_q,      dig_d;

    logic [DIGIT_W-1:0]    cur_digit;
    logic                  cur_en;
    logic                  lead_zero;
    logic                  blank;

`ifdef SSD_SCAN_BLINK_EN
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d, act_mask_q, act_mask_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic                  blink_on_q, blink_on_d;
    logic                  cur_mask;
`endif

    // Double buffer: wrap commits old pending data before a same-cycle load re-arms it
    always_comb begin
        pend_val_d = pend_val_q;
        pend_en_d  = pend_en_q;
        pend_lzb_d = pend_lzb_q;
        act_val_d  = act_val_q;
        act_en_d   = act_en_q;
        act_lzb_d  = act_lzb_q;
        pending_d  = pending_q;
        if (tick && pending_q) begin
            act_val_d = pend_val_q;
            act_en_d  = pend_en_q;
            act_lzb_d = pend_lzb_q;
        end
        if (load) begin
            pend_val_d = value;
            pend_en_d  = digit_en;
            pend_lzb_d = lzb_en;
            pending_d  = 1'b1;
        end else if (tick) begin
            pending_d  = 1'b0;
        end
    end

`ifdef SSD_SCAN_BLINK_EN
    // Blink phase flips every BLINK_FRAMES frame ticks
    always_comb begin
        pend_mask_d = pend_mask_q;
        act_mask_d  = act_mask_q;
        fcnt_d      = fcnt_q;
        blink_on_d  = blink_on_q;
        if (tick && pending_q) begin
            act_mask_d = pend_mask_q;
        end
        if (load) begin
            pend_mask_d = blink_mask;
        end
        if (tick) begin
            if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt_d     = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                fcnt_d     = fcnt_q + FCNT_W'(1);
            end
        end
    end
`endif

    // Digit selection and blanking for the current scan slot
    always_comb begin
        cur_digit = '0;
        cur_en    = 1'b0;
        lead_zero = 1'b1;
`ifdef SSD_SCAN_BLINK_EN
        cur_mask  = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            // lead_zero: this digit and every more-significant digit are zero
            if (IDX_W'(i) >= idx && act_val_q[i*DIGIT_W +: DIGIT_W] != '0) begin
                lead_zero = 1'b0;
            end
            if (IDX_W'(i) == idx) begin
                cur_digit = act_val_q[i*DIGIT_W +: DIGIT_W];
                cur_en    = act_en_q[i];
`ifdef SSD_SCAN_BLINK_EN
                cur_mask  = act_mask_q[i];
`endif
            end
        end
        blank = !cur_en || (act_lzb_q && lead_zero && (idx != '0));
`ifdef SSD_SCAN_BLINK_EN
        blank = blank || (!blink_on_q && cur_mask);
`endif
        seg_d = blank ? '0 : hex_to_seg(cur_digit);
        dig_d = blank ? '0 : NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_val_q <= '0;
            pend_en_q  <= '0;
            pend_lzb_q <= 1'b0;
            act_val_q  <= '0;
            act_en_q   <= '0;
            act_lzb_q  <= 1'b0;
            pending_q  <= 1'b0;
            seg_q      <= '0;
            dig_q      <= '0;
        end else begin
            pend_val_q <= pend_val_d;
            pend_en_q  <= pend_en_d;
            pend_lzb_q <= pend_lzb_d;
            act_val_q  <= act_val_d;
            act_en_q   <= act_en_d;
            act_lzb_q  <= act_lzb_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
        end
    end

`ifdef SSD_SCAN_BLINK_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_mask_q <= '0;
            act_mask_q  <= '0;
            fcnt_q      <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            pend_mask_q <= pend_mask_d;
            act_mask_q  <= act_mask_d;
            fcnt_q      <= fcnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_tick = tick;
    assign pending    = pending_q;

endmodule
